// File: rtl/ucdp_hs_pkg.sv
// Shared types for the request/acknowledge CDC handshake pair (source and target side).
package ucdp_hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } hs_state_t;

    localparam logic [1:0] hs_mode_four_phase_e = 2'h0;
    localparam logic [1:0] hs_mode_two_phase_e  = 2'h1;

endpackage

// File: rtl/ucdp_sync.sv
// Two-flop level synchronizer with optional edge detection on the synchronized level.
module ucdp_sync #(
    parameter logic        rstval_p    = 1'b0,
    parameter int unsigned edge_type_p = 0  // 0 none, 1 rise, 2 fall, 3 any
) (
    input  logic tgt_clk_i,
    input  logic tgt_rst_an_i,
    input  logic dft_mode_test_mode_i,
    input  logic dft_mode_scan_mode_i,
    input  logic dft_mode_scan_shift_i,
    input  logic dft_mode_mbist_mode_i,
    input  logic d_i,
    output logic q_o,
    output logic edge_o
);

    logic meta_q;
    logic sync_q;
    logic sync_dly_q;
    logic unused_dft;

    assign unused_dft = dft_mode_test_mode_i ^ dft_mode_scan_mode_i ^ dft_mode_mbist_mode_i;

    always_ff @(posedge tgt_clk_i or negedge tgt_rst_an_i) begin
        if (!tgt_rst_an_i) begin
            meta_q     <= rstval_p;
            sync_q     <= rstval_p;
            sync_dly_q <= rstval_p;
        end else begin
            meta_q     <= d_i;
            sync_q     <= meta_q;
            sync_dly_q <= sync_q;
        end
    end

    // Hold the reset level while shifting so scan data never reaches functional logic.
    assign q_o = dft_mode_scan_shift_i ? rstval_p : sync_q;

    always_comb begin
        edge_o = 1'b0;
        case (edge_type_p)
            1:       edge_o = sync_q & ~sync_dly_q;
            2:       edge_o = ~sync_q & sync_dly_q;
            3:       edge_o = sync_q ^ sync_dly_q;
            default: edge_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ucdp_hs_src.sv
// Source side of a req/ack CDC handshake: accepts a word on valid/ready and holds it
// on a registered data bus while a level (four-phase) or toggle (two-phase) request is pending.
module ucdp_hs_src
    import ucdp_hs_pkg::*;
#(
    parameter int unsigned dwidth_p = 8,
    parameter logic [1:0]  mode_p   = hs_mode_four_phase_e
) (
    input  logic                src_clk_i,
    input  logic                src_rst_an_i,
    input  logic                dft_mode_test_mode_i,
    input  logic                dft_mode_scan_mode_i,
    input  logic                dft_mode_scan_shift_i,
    input  logic                dft_mode_mbist_mode_i,
    input  logic                valid_i,
    input  logic [dwidth_p-1:0] data_i,
    output logic                ready_o,
    output logic                req_o,
    output logic [dwidth_p-1:0] data_o,
    input  logic                ack_i,
    output logic                busy_o,
    output logic                done_o
);

    localparam bit two_phase_p = (mode_p == hs_mode_two_phase_e);

    hs_state_t           state_q, state_d;
    logic                req_q, req_d;
    logic [dwidth_p-1:0] data_q, data_d;
    logic                done_q, done_d;
    logic                ack_s;
    logic                unused_ack_edge;

    ucdp_sync #(
        .rstval_p   (1'b0),
        .edge_type_p(0)
    ) u_ack_sync (
        .tgt_clk_i            (src_clk_i),
        .tgt_rst_an_i         (src_rst_an_i),
        .dft_mode_test_mode_i (dft_mode_test_mode_i),
        .dft_mode_scan_mode_i (dft_mode_scan_mode_i),
        .dft_mode_scan_shift_i(dft_mode_scan_shift_i),
        .dft_mode_mbist_mode_i(dft_mode_mbist_mode_i),
        .d_i                  (ack_i),
        .q_o                  (ack_s),
        .edge_o               (unused_ack_edge)
    );

    // A stale acknowledge from a previous or aborted transfer blocks acceptance.
    assign ready_o = (state_q == IDLE) & (two_phase_p ? (ack_s == req_q) : ~ack_s);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_i && ready_o) begin
                    data_d  = data_i;
                    req_d   = two_phase_p ? ~req_q : 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (two_phase_p) begin
                    if (ack_s == req_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REL;
                end
            end
            REL: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge src_clk_i or negedge src_rst_an_i) begin
        if (!src_rst_an_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign req_o  = req_q;
    assign data_o = data_q;
    assign done_o = done_q;
    assign busy_o = (state_q != IDLE);

`ifndef SYNTHESIS
    bit ack_s_prev;
    bit warned;
    bit mode_flagged;

    always @(posedge src_clk_i) begin
        ack_s_prev <= ack_s;
        if (!mode_flagged && (mode_p > hs_mode_two_phase_e)) begin
            $error("%m: illegal mode_p %0d", mode_p);
            mode_flagged <= 1'b1;
        end
        if (!warned && src_rst_an_i && (state_q == IDLE) && (ack_s != ack_s_prev) &&
            (ack_s_prev == req_q)) begin
            $warning("%m: acknowledge changed with no request pending");
            warned <= 1'b1;
        end
    end
`endif

endmodule
